// File: rtl/noise_gate_pkg.sv
// Shared types, default sizes and the unity-gain helper for the AXI-stream noise gate.
package noise_gate_pkg;

  localparam int NG_DATA_WIDTH = 24;
  localparam int NG_GAIN_W     = 16;
  localparam int NG_HOLD_W     = 16;

  typedef enum logic [2:0] {
    CLOSED,
    ATTACK,
    OPEN,
    HOLD,
    RELEASE
  } ng_state_e;

  function automatic int unity(input int gain_w);
    return 1 << gain_w;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-stream bundle carrying one signed sample per beat.
interface axis_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ng_gain_mult.sv
// Combinational signed sample x unsigned gain, scaled back by an arithmetic shift, with a bypass mux.
module ng_gain_mult #(
  parameter int DATA_WIDTH = 24,
  parameter int GAIN_W     = 16
) (
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [GAIN_W:0]       gain,
  input  logic                  bypass,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int PW = DATA_WIDTH + GAIN_W + 2;

  logic signed [PW-1:0] din_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] product;
  logic signed [PW-1:0] shifted;
  logic                 unused_shifted_hi;

  // Gain never exceeds unity, so the scaled result always fits back in DATA_WIDTH bits.
  assign din_ext  = {{(GAIN_W + 2){din[DATA_WIDTH-1]}}, din};
  assign gain_ext = {{(DATA_WIDTH + 1){1'b0}}, gain};
  assign product  = din_ext * gain_ext;
  assign shifted  = product >>> GAIN_W;

  assign dout              = bypass ? din : shifted[DATA_WIDTH-1:0];
  assign unused_shifted_hi = ^shifted[PW-1:DATA_WIDTH];

endmodule

// File: rtl/axis_noise_gate.sv
// AXI-stream noise gate: a per-beat FSM ramps a soft gain that is applied through a one-beat output register.
// Define NOISE_GATE_HYST_EN to close on thresh_close instead of thresh_open.
module axis_noise_gate
  import noise_gate_pkg::*;
#(
  parameter int DATA_WIDTH = NG_DATA_WIDTH,
  parameter int GAIN_W     = NG_GAIN_W,
  parameter int HOLD_W     = NG_HOLD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  axis_if.slave                 axis_in,
  axis_if.master                axis_out,
  input  logic [DATA_WIDTH-2:0] thresh_open,
  input  logic [DATA_WIDTH-2:0] thresh_close,
  input  logic [HOLD_W-1:0]     hold_frames,
  input  logic [GAIN_W:0]       attack_step,
  input  logic [GAIN_W:0]       release_step,
  input  logic                  bypass,
  output logic                  gate_open
);

  localparam int              UNITY_I = unity(GAIN_W);
  localparam logic [GAIN_W:0] UNITY   = UNITY_I[GAIN_W:0];

  ng_state_e               state;
  logic [GAIN_W:0]         gain;
  logic [HOLD_W-1:0]       hold_cnt;

  logic                    in_ready;
  logic                    accept;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_last;
  logic [DATA_WIDTH-1:0]   gated;

  logic [DATA_WIDTH-2:0]   neg_mag;
  logic [DATA_WIDTH-2:0]   mag;
  logic [DATA_WIDTH-2:0]   close_thr;
  logic                    above_open;
  logic                    above_close;

  logic [GAIN_W+1:0]       gain_sum;
  logic [GAIN_W:0]         gain_attack;
  logic [GAIN_W:0]         gain_release;

  assign in_ready       = !out_valid || axis_out.tready;
  assign axis_in.tready = in_ready;
  assign accept         = axis_in.tvalid && in_ready;

  assign axis_out.tvalid = out_valid;
  assign axis_out.tdata  = out_data;
  assign axis_out.tlast  = out_last;

  // Negating only the low bits gives |x| for every negative x except the most negative one.
  assign neg_mag = '0 - axis_in.tdata[DATA_WIDTH-2:0];

  always_comb begin
    mag = axis_in.tdata[DATA_WIDTH-2:0];
    if (axis_in.tdata[DATA_WIDTH-1]) begin
      if (axis_in.tdata[DATA_WIDTH-2:0] == '0) begin
        mag = '1;
      end else begin
        mag = neg_mag;
      end
    end
  end

`ifdef NOISE_GATE_HYST_EN
  assign close_thr = thresh_close;
`else
  logic unused_thresh_close;
  assign close_thr           = thresh_open;
  assign unused_thresh_close = ^thresh_close;
`endif

  assign above_open  = (mag >= thresh_open);
  assign above_close = (mag >= close_thr);

  assign gain_sum     = {1'b0, gain} + {1'b0, attack_step};
  assign gain_attack  = (gain_sum >= {1'b0, UNITY}) ? UNITY : gain_sum[GAIN_W:0];
  assign gain_release = (release_step >= gain) ? '0 : (gain - release_step);

  ng_gain_mult #(
    .DATA_WIDTH(DATA_WIDTH),
    .GAIN_W    (GAIN_W)
  ) u_mult (
    .din   (axis_in.tdata),
    .gain  (gain),
    .bypass(bypass),
    .dout  (gated)
  );

  // One-deep output register; a reset drops whatever beat is waiting in it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= gated;
      out_last  <= axis_in.tlast;
    end else if (axis_out.tready) begin
      out_valid <= 1'b0;
    end
  end

  // The beat that enters ATTACK or RELEASE already applies that state's gain step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLOSED;
      gain      <= '0;
      hold_cnt  <= '0;
      gate_open <= 1'b0;
    end else if (accept) begin
      case (state)
        CLOSED: begin
          if (above_open) begin
            gain      <= gain_attack;
            state     <= (gain_attack == UNITY) ? OPEN : ATTACK;
            gate_open <= 1'b1;
          end
        end
        ATTACK: begin
          gain <= gain_attack;
          if (gain_attack == UNITY) begin
            state <= OPEN;
          end
        end
        OPEN: begin
          if (!above_close) begin
            if (hold_frames == '0) begin
              gain      <= gain_release;
              state     <= (gain_release == '0) ? CLOSED : RELEASE;
              gate_open <= 1'b0;
            end else begin
              hold_cnt <= hold_frames;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (above_open) begin
            state <= OPEN;
          end else if (axis_in.tlast) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
            if (hold_cnt[HOLD_W-1:1] == '0) begin
              gain      <= gain_release;
              state     <= (gain_release == '0) ? CLOSED : RELEASE;
              gate_open <= 1'b0;
            end
          end
        end
        RELEASE: begin
          if (above_open) begin
            gain      <= gain_attack;
            state     <= (gain_attack == UNITY) ? OPEN : ATTACK;
            gate_open <= 1'b1;
          end else begin
            gain <= gain_release;
            if (gain_release == '0) begin
              state <= CLOSED;
            end
          end
        end
        default: begin
          state     <= CLOSED;
          gate_open <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_noise_gate.sv
// Self-checking bench for axis_noise_gate: directed scenarios plus randomized traffic against a behavioural gain model.
`timescale 1ns/1ps
module tb_axis_noise_gate;
  import noise_gate_pkg::*;

  localparam int DW = 24;
  localparam int GW = 16;
  localparam int HW = 16;
  localparam longint U = 65536;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-2:0] thresh_open;
  logic [DW-2:0] thresh_close;
  logic [HW-1:0] hold_frames;
  logic [GW:0]   attack_step;
  logic [GW:0]   release_step;
  logic          bypass;
  logic          gate_open;

  axis_if #(.DATA_WIDTH(DW)) in_if ();
  axis_if #(.DATA_WIDTH(DW)) out_if ();

  axis_noise_gate #(
    .DATA_WIDTH(DW),
    .GAIN_W    (GW),
    .HOLD_W    (HW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .axis_in     (in_if),
    .axis_out    (out_if),
    .thresh_open (thresh_open),
    .thresh_close(thresh_close),
    .hold_frames (hold_frames),
    .attack_step (attack_step),
    .release_step(release_step),
    .bypass      (bypass),
    .gate_open   (gate_open)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit stream_done;

  logic [DW:0] exp_q[$];
  logic [DW:0] out_q[$];

  typedef enum {M_CLOSED, M_ATTACK, M_OPEN, M_HOLD, M_RELEASE} m_state_e;
  m_state_e m_state;
  longint   m_gain;
  longint   m_hcnt;

  // Output collector: a handshake seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!rst && out_if.tvalid === 1'b1 && out_if.tready === 1'b1)
      out_q.push_back({out_if.tlast, out_if.tdata});
  end

  function automatic void model_reset();
    m_state = M_CLOSED;
    m_gain  = 0;
    m_hcnt  = 0;
  endfunction

  function automatic void m_attack();
    m_gain = m_gain + longint'(attack_step);
    if (m_gain > U) m_gain = U;
    m_state = (m_gain == U) ? M_OPEN : M_ATTACK;
  endfunction

  function automatic void m_release();
    m_gain = m_gain - longint'(release_step);
    if (m_gain < 0) m_gain = 0;
    m_state = (m_gain == 0) ? M_CLOSED : M_RELEASE;
  endfunction

  // Expected output beat for one accepted input, using the gain held before this beat.
  function automatic logic [DW:0] model_beat(input logic [DW-1:0] d, input logic last);
    longint x, mag, open_thr, close_thr;
    int     outv;
    x        = longint'($signed(d));
    mag      = (x < 0) ? -x : x;
    if (mag > 8388607) mag = 8388607;
    outv     = bypass ? int'(x) : int'((x * m_gain) >>> GW);
    open_thr = longint'(thresh_open);
`ifdef NOISE_GATE_HYST_EN
    close_thr = longint'(thresh_close);
`else
    close_thr = open_thr;
`endif
    case (m_state)
      M_CLOSED:  if (mag >= open_thr) m_attack();
      M_ATTACK:  m_attack();
      M_OPEN: begin
        if (mag < close_thr) begin
          if (hold_frames == 0) m_release();
          else begin
            m_hcnt  = longint'(hold_frames);
            m_state = M_HOLD;
          end
        end
      end
      M_HOLD: begin
        if (mag >= open_thr) m_state = M_OPEN;
        else if (last) begin
          m_hcnt = m_hcnt - 1;
          if (m_hcnt <= 0) m_release();
        end
      end
      M_RELEASE: begin
        if (mag >= open_thr) m_attack();
        else m_release();
      end
      default: m_state = M_CLOSED;
    endcase
    return {last, outv[DW-1:0]};
  endfunction

  function automatic logic [DW-1:0] rand_sample();
    int v;
    int sel;
    sel = $urandom_range(0, 5);
    case (sel)
      0:       v = -8388608;
      1:       v = $urandom_range(0, 2000);
      2:       v = $urandom_range(0, 9000);
      default: v = int'($urandom) >>> 8;
    endcase
    if ((sel == 1 || sel == 2) && $urandom_range(0, 1) == 1) v = -v;
    return v[DW-1:0];
  endfunction

  task automatic applyStimulus(input logic [DW-1:0] d, input logic last);
    bit done;
    done = 1'b0;
    in_if.tdata  = d;
    in_if.tlast  = last;
    in_if.tvalid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_if.tready === 1'b1) begin
        exp_q.push_back(model_beat(d, last));
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: input beat %0h not accepted within 200 cycles", d);
    end else begin
      @(posedge clk);
      #1;
    end
    in_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    out_if.tready = 1'b1;
    for (int c = 0; c < 100 && out_q.size() < exp_q.size(); c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    thresh_open   = 23'd4096;
    thresh_close  = 23'd4096;
    hold_frames   = 16'd2;
    attack_step   = 17'd16384;
    release_step  = 17'd32768;
    bypass        = 1'b0;
    in_if.tvalid  = 1'b0;
    in_if.tdata   = '0;
    in_if.tlast   = 1'b0;
    out_if.tready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    out_q.delete();
  endtask

  task automatic test_reset();
    set_defaults();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_if.tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tvalid got=%b want=0", out_if.tvalid); end
    n_checks++; if (out_if.tdata !== '0) begin n_fail++; $display("[TB] FAIL reset_tdata got=%0h want=0", out_if.tdata); end
    n_checks++; if (out_if.tlast !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tlast got=%b want=0", out_if.tlast); end
    n_checks++; if (gate_open !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gate_open got=%b want=0", gate_open); end
    n_checks++; if (dut.state !== CLOSED) begin n_fail++; $display("[TB] FAIL reset_state got=%0d want=%0d", dut.state, CLOSED); end
    n_checks++; if (dut.gain !== '0) begin n_fail++; $display("[TB] FAIL reset_gain got=%0d want=0", dut.gain); end
    n_checks++; if (dut.hold_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset_hold_cnt got=%0d want=0", dut.hold_cnt); end
    do_reset();
    n_checks++; if (in_if.tready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tready got=%b want=1", in_if.tready); end
  endtask

  task automatic test_closed();
    int v;
    int got;
    exp_q.delete(); out_q.delete();
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? 1000 : -1000;
      applyStimulus(v[DW-1:0], (i % 2 == 1));
      n_checks++; if (gate_open !== 1'b0) begin n_fail++; $display("[TB] FAIL closed_gate_open beat %0d got=%b want=0", i, gate_open); end
    end
    drain();
    n_checks++; if (out_q.size() != 8) begin n_fail++; $display("[TB] FAIL closed_count got=%0d want=8", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 8; i++) begin
      got = int'($signed(out_q[i][DW-1:0]));
      n_checks++; if (got != 0) begin n_fail++; $display("[TB] FAIL closed_data beat %0d got=%0d want=0", i, got); end
    end
    n_checks++; if (dut.state !== CLOSED) begin n_fail++; $display("[TB] FAIL closed_state got=%0d want=%0d", dut.state, CLOSED); end
  endtask

  task automatic test_attack();
    int exp_tab[6];
    int got;
    int v;
    exp_tab = '{0, 25000, 50000, 75000, 100000, 100000};
    v = 100000;
    exp_q.delete(); out_q.delete();
    attack_step = 17'd16384;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(v[DW-1:0], (i % 2 == 1));
      if (i == 2) begin
        n_checks++; if (dut.state !== ATTACK) begin n_fail++; $display("[TB] FAIL attack_state_b3 got=%0d want=%0d", dut.state, ATTACK); end
      end
      if (i == 3) begin
        n_checks++; if (dut.state !== OPEN) begin n_fail++; $display("[TB] FAIL attack_state_b4 got=%0d want=%0d", dut.state, OPEN); end
      end
      n_checks++; if (gate_open !== 1'b1) begin n_fail++; $display("[TB] FAIL attack_gate_open beat %0d got=%b want=1", i, gate_open); end
    end
    drain();
    n_checks++; if (out_q.size() != 6) begin n_fail++; $display("[TB] FAIL attack_count got=%0d want=6", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 6; i++) begin
      got = int'($signed(out_q[i][DW-1:0]));
      n_checks++; if (got != exp_tab[i]) begin n_fail++; $display("[TB] FAIL attack_data beat %0d got=%0d want=%0d", i, got, exp_tab[i]); end
      n_checks++; if (out_q[i][DW] !== (i % 2 == 1)) begin n_fail++; $display("[TB] FAIL attack_tlast beat %0d got=%b", i, out_q[i][DW]); end
    end
  endtask

  task automatic test_hold_release();
    int exp_tab[6];
    int got;
    int v;
    exp_tab = '{10, 10, 10, 10, 5, 0};
    v = 10;
    exp_q.delete(); out_q.delete();
    hold_frames  = 16'd2;
    release_step = 17'd32768;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(v[DW-1:0], (i % 2 == 1));
      if (i == 0) begin
        n_checks++; if (dut.state !== HOLD) begin n_fail++; $display("[TB] FAIL hold_state_b1 got=%0d want=%0d", dut.state, HOLD); end
      end
      if (i == 2) begin
        n_checks++; if (gate_open !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_gate_open_b3 got=%b want=1", gate_open); end
      end
      if (i == 3) begin
        n_checks++; if (gate_open !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_gate_open_b4 got=%b want=0", gate_open); end
      end
      if (i >= 4) begin
        n_checks++; if (dut.state !== CLOSED) begin n_fail++; $display("[TB] FAIL release_state beat %0d got=%0d want=%0d", i, dut.state, CLOSED); end
      end
    end
    drain();
    n_checks++; if (out_q.size() != 6) begin n_fail++; $display("[TB] FAIL hold_count got=%0d want=6", out_q.size()); end
    for (int i = 0; i < out_q.size() && i < 6; i++) begin
      got = int'($signed(out_q[i][DW-1:0]));
      n_checks++; if (got != exp_tab[i]) begin n_fail++; $display("[TB] FAIL hold_data beat %0d got=%0d want=%0d", i, got, exp_tab[i]); end
    end
  endtask

  task automatic test_reset_midbeat();
    int v;
    v = 100000;
    exp_q.delete(); out_q.delete();
    attack_step   = 17'd65536;
    out_if.tready = 1'b0;
    applyStimulus(v[DW-1:0], 1'b0);
    n_checks++; if (out_if.tvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL midbeat_pending got=%b want=1", out_if.tvalid); end
    n_checks++; if (gate_open !== 1'b1) begin n_fail++; $display("[TB] FAIL midbeat_gate_before got=%b want=1", gate_open); end
    rst = 1'b1;
    #1;
    n_checks++; if (out_if.tvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL midbeat_tvalid got=%b want=0", out_if.tvalid); end
    n_checks++; if (out_if.tdata !== '0) begin n_fail++; $display("[TB] FAIL midbeat_tdata got=%0h want=0", out_if.tdata); end
    n_checks++; if (gate_open !== 1'b0) begin n_fail++; $display("[TB] FAIL midbeat_gate_after got=%b want=0", gate_open); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    out_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_q.size() != 0) begin n_fail++; $display("[TB] FAIL midbeat_leak got=%0d beats want=0", out_q.size()); end
    n_checks++; if (in_if.tready !== 1'b1) begin n_fail++; $display("[TB] FAIL midbeat_tready got=%b want=1", in_if.tready); end
  endtask

  task automatic test_min_value();
    int v;
    exp_q.delete(); out_q.delete();
    attack_step = 17'd65536;
    v = 100000;
    applyStimulus(v[DW-1:0], 1'b0);
    in_if.tdata = 24'h800000;
    #1;
    n_checks++; if (dut.mag !== 23'h7FFFFF) begin n_fail++; $display("[TB] FAIL min_mag got=%0d want=8388607", dut.mag); end
    applyStimulus(24'h800000, 1'b1);
    n_checks++; if (gate_open !== 1'b1) begin n_fail++; $display("[TB] FAIL min_gate_open got=%b want=1", gate_open); end
    n_checks++; if (dut.state !== OPEN) begin n_fail++; $display("[TB] FAIL min_state got=%0d want=%0d", dut.state, OPEN); end
    drain();
    n_checks++; if (out_q.size() != 2) begin n_fail++; $display("[TB] FAIL min_count got=%0d want=2", out_q.size()); end
    else begin
      n_checks++; if (out_q[1][DW-1:0] !== 24'h800000) begin n_fail++; $display("[TB] FAIL min_data got=%0h want=800000", out_q[1][DW-1:0]); end
    end
  endtask

  task automatic test_hysteresis();
    ng_state_e want;
    int v;
`ifdef NOISE_GATE_HYST_EN
    want = OPEN;
`else
    want = HOLD;
`endif
    exp_q.delete(); out_q.delete();
    thresh_open  = 23'd4096;
    thresh_close = 23'd2048;
    hold_frames  = 16'd2;
    v = 3000;
    applyStimulus(v[DW-1:0], 1'b0);
    n_checks++; if (dut.state !== want) begin n_fail++; $display("[TB] FAIL hyst_state got=%0d want=%0d", dut.state, want); end
    n_checks++; if (gate_open !== 1'b1) begin n_fail++; $display("[TB] FAIL hyst_gate_open got=%b want=1", gate_open); end
    drain();
    n_checks++; if (out_q.size() != 1 || out_q[0][DW-1:0] !== 24'd3000) begin
      n_fail++; $display("[TB] FAIL hyst_data got=%0d beats first=%0h want=1 beat 3000", out_q.size(), (out_q.size() > 0) ? out_q[0][DW-1:0] : 24'h0);
    end
    thresh_close = 23'd4096;
  endtask

  task automatic test_backpressure();
    logic [DW:0] held;
    exp_q.delete(); out_q.delete();
    out_if.tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) applyStimulus(rand_sample(), (i % 2 == 0));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_if.tready = 1'b0;
        held = {out_if.tlast, out_if.tdata};
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          n_checks++; if (out_if.tvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_tvalid cycle %0d got=%b want=1", k, out_if.tvalid); end
          n_checks++; if (in_if.tready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_tready cycle %0d got=%b want=0", k, in_if.tready); end
          n_checks++; if ({out_if.tlast, out_if.tdata} !== held) begin n_fail++; $display("[TB] FAIL stall_stable cycle %0d got=%0h want=%0h", k, {out_if.tlast, out_if.tdata}, held); end
        end
        @(posedge clk);
        #1;
        out_if.tready = 1'b1;
      end
    join
    drain();
    n_checks++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL bp_count got=%0d want=%0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (out_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL bp_beat %0d got=%0h want=%0h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    do_reset();
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if (i % 16 == 0) begin
            thresh_open  = 23'($urandom_range(0, 20000));
            thresh_close = 23'($urandom_range(0, 20000));
            hold_frames  = 16'($urandom_range(0, 3));
            attack_step  = ($urandom_range(0, 3) == 0) ? 17'd0 : 17'($urandom_range(1, 70000));
            release_step = ($urandom_range(0, 3) == 0) ? 17'd0 : 17'($urandom_range(1, 70000));
            bypass       = ($urandom_range(0, 7) == 0);
          end
          applyStimulus(rand_sample(), (i % 2 == 1));
          n_checks++;
          if (gate_open !== (m_state inside {M_ATTACK, M_OPEN, M_HOLD})) begin
            n_fail++; $display("[TB] FAIL rand_gate_open beat %0d got=%b model_state=%0d", i, gate_open, m_state);
          end
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_if.tready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          n_checks++;
          if (in_if.tready !== (!out_if.tvalid || out_if.tready)) begin
            n_fail++; $display("[TB] FAIL rand_in_tready got=%b out_tvalid=%b out_tready=%b", in_if.tready, out_if.tvalid, out_if.tready);
          end
        end
        out_if.tready = 1'b1;
      end
    join
    drain();
    n_checks++; if (out_q.size() != exp_q.size()) begin n_fail++; $display("[TB] FAIL rand_count got=%0d want=%0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (out_q[i] !== exp_q[i]) begin n_fail++; $display("[TB] FAIL rand_beat %0d got=%0h want=%0h", i, out_q[i], exp_q[i]); end
    end
    bypass = 1'b0;
  endtask

  initial begin
    $display("[TB] starting axis_noise_gate bench");
    test_reset();
    test_closed();
    test_attack();
    test_hold_release();
    test_reset_midbeat();
    test_min_value();
    test_hysteresis();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_noise_gate.md
AXIS_NOISE_GATE -- requirements
Module: axis_noise_gate

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, giving the signed two's-complement sample width carried in tdata.
REQ-002 SHALL have parameter GAIN_W, default 16, giving the gain fraction bits; unity gain is 2^GAIN_W.
REQ-003 SHALL have parameter HOLD_W, default 16, giving the hold counter width in stereo frames.
REQ-004 Port list (name  direction  width  meaning):
- clk  in  1  single clock; all logic is synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- axis_in  axis_if.slave  DATA_WIDTH  sample stream from i2s_rx; tlast marks the right-channel beat.
- axis_out  axis_if.master  DATA_WIDTH  gated sample stream.
- thresh_open  in  DATA_WIDTH-1  unsigned magnitude threshold that opens the gate.
- thresh_close  in  DATA_WIDTH-1  close threshold; used only when NOISE_GATE_HYST_EN is defined.
- hold_frames  in  HOLD_W  hold time, counted in tlast beats.
- attack_step  in  GAIN_W+1  gain increment per accepted beat.
- release_step  in  GAIN_W+1  gain decrement per accepted beat.
- bypass  in  1  pass data unmodified.
- gate_open  out  1  high in ATTACK, OPEN and HOLD.

Function
REQ-005 axis_in.tready SHALL equal !axis_out.tvalid || axis_out.tready.
REQ-006 Each accepted beat SHALL appear on axis_out exactly one cycle after acceptance, with tlast copied.
REQ-007 While axis_out.tvalid is high and tready is low, axis_out SHALL hold tdata and tlast stable.
REQ-008 mag SHALL be |tdata|, saturated to 2^(DATA_WIDTH-1)-1 when tdata = -2^(DATA_WIDTH-1).
REQ-009 Output data SHALL be (tdata*gain)>>>GAIN_W, using the arithmetic shift.
- gain is the register value before this beat's update.
- At unity gain, the output SHALL equal the input exactly.
REQ-010 When bypass=1, output SHALL equal the input; the FSM and gain SHALL continue updating.
REQ-011 FSM states SHALL be CLOSED, ATTACK, OPEN, HOLD and RELEASE; evaluation happens only on accepted beats.
- CLOSED: mag>=thresh_open goes to ATTACK.
- ATTACK: gain+=attack_step, saturating at 2^GAIN_W; on reaching unity go to OPEN.
- OPEN: mag<close_thr loads hold_cnt=hold_frames and goes to HOLD; if hold_frames=0, go directly to RELEASE.
- HOLD: mag>=thresh_open returns to OPEN. Otherwise, on a tlast beat, hold_cnt decrements; when hold_cnt reaches 0, go to RELEASE.
- RELEASE: mag>=thresh_open goes to ATTACK. Otherwise gain-=release_step, saturating at 0; on reaching 0 go to CLOSED.
REQ-012 close_thr SHALL be thresh_open unless NOISE_GATE_HYST_EN is defined.
REQ-013 A step of 0 SHALL freeze gain in that state; there is no state timeout.
REQ-014 Config inputs SHALL be sampled on each accepted beat; changes take effect on the next beat.

Reset
REQ-015 During and after rst the block SHALL be in the following state:
- state=CLOSED, gain=0, hold_cnt=0.
- axis_out.tvalid=0, tdata=0, tlast=0.
- gate_open=0.
- axis_in.tready=1 after reset release.
REQ-016 rst asserted mid-beat SHALL discard the in-flight output beat.

Configuration
REQ-017 With NOISE_GATE_HYST_EN defined, OPEN->HOLD SHALL use thresh_close; thresh_close>thresh_open is legal and means it closes immediately.
REQ-018 Without NOISE_GATE_HYST_EN, thresh_close SHALL be ignored, and the build SHALL tolerate it being unconnected.

Structure
REQ-019 Package noise_gate_pkg SHALL hold:
- the state enum ng_state_e;
- function unity(GAIN_W);
- the default parameter constants.
REQ-020 Sub-module ng_gain_mult SHALL implement the combinational multiply-and-shift of REQ-009, including the bypass mux.

Verification (DATA_WIDTH=24, GAIN_W=16, unity=65536)
REQ-021 Reset, thresh_open=4096, input ±1000 -> output all 0, gate_open=0, state CLOSED.
REQ-022 Input constant 100000, attack_step=16384 -> output 0,25000,50000,75000,100000; OPEN after 4 beats.
REQ-023 From OPEN, hold_frames=2, release_step=32768, input 10 -> 10 for 4 beats (2 frames), then 5, 0, and CLOSED.
REQ-024 axis_out.tready low 5 cycles mid-stream -> axis_in.tready low, output stable, no beat lost or duplicated, order preserved.
REQ-025 OPEN with input -8388608 -> output -8388608, mag=8388607, gate stays open.
REQ-026 thresh_open=4096, thresh_close=2048, OPEN with input 3000:
- with NOISE_GATE_HYST_EN: stays OPEN;
- without it: enters HOLD.
